serial_subtractor: RTL

Multi-cycle, bit-serial N-bit subtractor that computes a − b − bi, processing K bits per clock, LSB first. It is the inverse-direction companion of the team's N-bit adders. It serves area-constrained datapaths where a full-width subtractor is not justified. A start/busy/done handshake wraps it, and outputs are held stable between operations.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for serial_subtractor: master requests, slave computes.
interface serial_subtractor_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, diff, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, diff, bo
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bi, K bits per clock, LSB first,
// wrapped in a start/busy/done handshake with result held between operations.
module serial_subtractor #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned STEPS = N / K;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    generate
        if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $error("serial_subtractor: need 1 <= K <= N and N a multiple of K");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_last;

    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_part;
    logic          r_borrow;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_diff;
    logic          r_bo;
    logic          r_done;

    logic [K:0]    w_step;
    logic [K-1:0]  w_chunk;
    logic          w_borrow;
    logic [N-1:0]  w_part_nxt;

    // (K+1)-bit difference: bit K is set exactly when the chunk underflows.
    assign w_step     = {1'b0, r_a_sh[K-1:0]} - {1'b0, r_b_sh[K-1:0]} - {{K{1'b0}}, r_borrow};
    assign w_chunk    = w_step[K-1:0];
    assign w_borrow   = w_step[K];
    // Written as shift/or so that K == N needs no zero-width slice.
    assign w_part_nxt = (r_part >> K) | (N'(w_chunk) << (N - K));
    assign w_last     = (r_cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_part   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bo     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh   <= bus.a;
                r_b_sh   <= bus.b;
                r_borrow <= bus.bi;
                r_part   <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                r_a_sh   <= r_a_sh >> K;
                r_b_sh   <= r_b_sh >> K;
                r_part   <= w_part_nxt;
                r_borrow <= w_borrow;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_diff <= w_part_nxt;
                    r_bo   <= w_borrow;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bo   = r_bo;
endmodule
